// File: rtl/wb_cmd_initiator.sv
// Wishbone classic-cycle initiator: one bus cycle per command taken on a valid/ready port,
// with the result (read data or timeout error) returned on a valid/ready response port.
`timescale 1ns/1ps
module wb_cmd_initiator #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    output logic            busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid and its payload stay stable until that edge, ready never depends on valid.
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              cmd_ready_d, rsp_valid_d, rsp_err_d, cyc_d, we_d, busy_d;
    logic [DW-1:0]     rsp_dat_d, dat_d;
    logic [AW-1:0]     adr_d;
    logic [DW/8-1:0]   sel_d;
    logic              accept, timeout_hit;

    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));
    assign wbm_stb_o   = wbm_cyc_o;

    // State and every output are registered here
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_dat   <= rsp_dat_d;
            rsp_err   <= rsp_err_d;
            wbm_cyc_o <= cyc_d;
            wbm_we_o  <= we_d;
            wbm_sel_o <= sel_d;
            wbm_adr_o <= adr_d;
            wbm_dat_o <= dat_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (wbm_ack_i || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = rsp_valid;
        rsp_dat_d   = rsp_dat;
        rsp_err_d   = rsp_err;
        cyc_d       = wbm_cyc_o;
        we_d        = wbm_we_o;
        sel_d       = wbm_sel_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cyc_d       = 1'b1;
                    we_d        = cmd_we;
                    sel_d       = cmd_sel;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                end
            end
            BUS: begin
                // An ack on the last allowed cycle takes priority over the timeout
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = '0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator: a small adder-register responder on the bus and a
// register-file model that predicts each response from the command stream.
`timescale 1ns/1ps
module tb_wb_cmd_initiator;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;
    localparam int W   = 1 + 8 + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, busy;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // responder controls
    bit            ack_en, ovr_en, late_ack;
    int            ack_dly, wcnt;
    logic [DW-1:0] ovr_dat;
    logic [DW-1:0] regs [4];
    // reference model of the responder's register contents
    logic [DW-1:0] m [4];

    // clock / reset
    always #5 clk = ~clk;

    wb_cmd_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    // responder: acks after ack_dly cycles of stb; address 2 reads reg0 + reg1
    assign wbm_ack_i = (wbm_cyc_o && wbm_stb_o && ack_en && (wcnt == ack_dly - 1)) || late_ack;
    assign wbm_dat_i = ovr_en ? ovr_dat :
                       (wbm_adr_o[1:0] == 2'd2) ? regs[0] + regs[1] : regs[wbm_adr_o[1:0]];

    always @(posedge clk) begin
        if (wbm_cyc_o && !wbm_ack_i) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        if (wbm_cyc_o && wbm_ack_i && wbm_we_o) regs[wbm_adr_o[1:0]] <= wbm_dat_o;
    end

    function automatic logic [DW-1:0] model_read(input logic [1:0] a);
        return (a == 2'd2) ? m[0] + m[1] : m[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: one full command/response transaction; ok drops on any protocol irregularity
    task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel, input int rdy_delay,
                          output logic [DW-1:0] rdat, output logic err, output int ncyc,
                          output bit ok);
        int n;
        ok = 1; ncyc = 0; n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        while (!cmd_ready && n < 50) begin step(); n++; end
        if (!cmd_ready) ok = 0;
        step();
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
        cmd_sel = 4'($urandom);
        while (wbm_cyc_o && ncyc < 200) begin
            if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
                wbm_dat_o !== dat || wbm_sel_o !== sel || cmd_ready !== 1'b0 ||
                busy !== 1'b1 || rsp_valid !== 1'b0) ok = 0;
            step();
            ncyc++;
        end
        if (rsp_valid !== 1'b1 || wbm_stb_o !== 1'b0 || busy !== 1'b1) ok = 0;
        rdat = rsp_dat;
        err  = rsp_err;
        repeat (rdy_delay) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_dat !== rdat || rsp_err !== err ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) ok = 0;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || wbm_cyc_o !== 1'b0) ok = 0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
             rsp_valid, rsp_err, rsp_dat, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rv=%b re=%b rd=%h busy=%b expected all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                     rsp_valid, rsp_err, rsp_dat, busy);
        end
        #3 rst = 1'b0;
        step();
    endtask

    task automatic test_adder();
        logic [DW-1:0] rd; logic er; int nc; bit ok;
        logic          we_t [3];
        logic [DW-1:0] adr_t [3];
        logic [DW-1:0] dat_t [3];
        we_t  = '{1'b1, 1'b1, 1'b0};
        adr_t = '{32'h0, 32'h1, 32'h2};
        dat_t = '{32'd5, 32'd7, 32'd0};
        ack_en = 1; ack_dly = 1; ovr_en = 0;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] e;
            e = {1'b0, 8'd1, we_t[i] ? 32'd0 : model_read(adr_t[i][1:0])};
            if (we_t[i]) m[adr_t[i][1:0]] = dat_t[i];
            do_cmd(we_t[i], adr_t[i], dat_t[i], 4'hF, 0, rd, er, nc, ok);
            checks++;
            if ({er, 8'(nc), rd} !== e) begin
                errors++; $display("FAIL adder_rsp[%0d]: got %h expected %h", i, {er, 8'(nc), rd}, e);
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL adder_protocol[%0d]: got 0 expected 1", i); end
        end
        checks++;
        if (m[0] + m[1] !== 32'd12 || rd !== 32'd12) begin
            errors++; $display("FAIL adder_sum: got %0d expected 12", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] rd; logic er; int nc; bit ok;
        ack_en = 1; ack_dly = 4; ovr_en = 1; ovr_dat = 32'hDEADBEEF;
        do_cmd(1'b0, 32'h2, 32'h0, 4'hF, 0, rd, er, nc, ok);
        ovr_en = 0;
        checks++;
        if ({er, 8'(nc), rd} !== {1'b0, 8'd4, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wait_rsp: got err=%b cyc=%0d dat=%h expected err=0 cyc=4 dat=deadbeef", er, nc, rd);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_stable: got 0 expected 1"); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd; logic er; int nc; bit ok;
        ack_en = 0;
        do_cmd(1'b1, 32'h0, 32'h1234_5678, 4'h3, 2, rd, er, nc, ok);
        checks++;
        if ({er, 8'(nc), rd} !== {1'b1, 8'(TMO), 32'h0} || !ok) begin
            errors++; $display("FAIL timeout_rsp: got err=%b cyc=%0d dat=%h ok=%b expected err=1 cyc=%0d dat=0 ok=1", er, nc, rd, ok, TMO);
        end
        ack_en = 1; ack_dly = 2;
        do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, nc, ok);
        checks++;
        if ({er, 8'(nc), rd} !== {1'b0, 8'd2, model_read(2'd0)} || !ok) begin
            errors++; $display("FAIL after_timeout: got err=%b cyc=%0d dat=%h ok=%b expected err=0 cyc=2 dat=%h", er, nc, rd, ok, model_read(2'd0));
        end
    endtask

    task automatic test_ack_last();
        logic [DW-1:0] rd; logic er; int nc; bit ok;
        ack_en = 1; ack_dly = TMO;
        do_cmd(1'b0, 32'h1, 32'h0, 4'hF, 0, rd, er, nc, ok);
        checks++;
        if ({er, 8'(nc), rd} !== {1'b0, 8'(TMO), model_read(2'd1)} || !ok) begin
            errors++; $display("FAIL ack_last: got err=%b cyc=%0d dat=%h expected err=0 cyc=%0d dat=%h", er, nc, rd, TMO, model_read(2'd1));
        end
        ack_dly = TMO + 1;
        do_cmd(1'b0, 32'h1, 32'h0, 4'hF, 0, rd, er, nc, ok);
        checks++;
        if ({er, 8'(nc), rd} !== {1'b1, 8'(TMO), 32'h0} || !ok) begin
            errors++; $display("FAIL ack_too_late: got err=%b cyc=%0d dat=%h expected err=1 cyc=%0d dat=0", er, nc, rd, TMO);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e; bit hold_ok; int n;
        ack_en = 1; ack_dly = 1;
        e = model_read(2'd2);
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h2; cmd_sel = 4'hF; cmd_dat = 0;
        n = 0;
        while (!cmd_ready && n < 20) begin step(); n++; end
        step();
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        hold_ok = 1;
        repeat (10) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_dat !== e || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) hold_ok = 0;
        end
        checks++;
        if (!hold_ok || rsp_dat !== e) begin
            errors++; $display("FAIL bp_hold: got ok=%b dat=%h expected ok=1 dat=%h", hold_ok, rsp_dat, e);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", cmd_ready, rsp_valid);
        end
        step();
        cmd_valid = 0;
        checks++;
        if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h2) begin
            errors++; $display("FAIL bp_next_accept: got cyc=%b adr=%h expected cyc=1 adr=2", wbm_cyc_o, wbm_adr_o);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_dat !== e || rsp_err !== 1'b0) begin
            errors++; $display("FAIL bp_next_rsp: got valid=%b dat=%h err=%b expected valid=1 dat=%h err=0", rsp_valid, rsp_dat, rsp_err, e);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    task automatic test_back_to_back();
        int acc, rsps;
        logic [DW-1:0] d;
        d = $urandom;
        ack_en = 1; ack_dly = 1;
        acc = 0; rsps = 0;
        rsp_ready = 1;
        cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h3; cmd_dat = d; cmd_sel = 4'hF;
        repeat (30) begin
            if (cmd_ready) acc++;
            if (rsp_valid) rsps++;
            step();
        end
        cmd_valid = 0;
        rsp_ready = 0;
        m[3] = d;
        checks++;
        if (acc !== 10 || rsps !== 10) begin
            errors++; $display("FAIL back_to_back: got accepts=%0d responses=%0d expected 10 and 10", acc, rsps);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, d; logic er, we; int nc, dly; bit ok;
        logic [1:0] a; logic [SW-1:0] s; logic [W-1:0] e, got;
        bit timed;
        ack_en = 1;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1)); a = 2'($urandom_range(0, 3));
            d = $urandom; s = 4'($urandom_range(0, 15)); dly = $urandom_range(1, TMO + 3);
            ack_dly = dly;
            timed = (dly > TMO);
            exp_q.push_back({timed, 8'(timed ? TMO : dly), (timed || we) ? 32'h0 : model_read(a)});
            if (!timed && we) m[a] = d;
            do_cmd(we, {30'h0, a}, d, s, $urandom_range(0, 3), rd, er, nc, ok);
            got = {er, 8'(nc), rd};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL rand_rsp[%0d]: got %h expected %h", i, got, e);
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_protocol[%0d]: got 0 expected 1", i); end
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] rd; logic er; int nc; bit ok, quiet;
        ack_en = 0;
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h1; cmd_sel = 4'hF; cmd_dat = 0;
        step();
        cmd_valid = 0;
        repeat (2) step();
        checks++;
        if (wbm_cyc_o !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_reset_pre: got cyc=%b busy=%b expected 1 1", wbm_cyc_o, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, busy, rsp_valid, cmd_ready} !== 5'b00001) begin
            errors++; $display("FAIL mid_reset_async: got cyc,stb,busy,rv,rdy=%b expected 00001",
                               {wbm_cyc_o, wbm_stb_o, busy, rsp_valid, cmd_ready});
        end
        #2 rst = 1'b0;
        late_ack = 1;
        quiet = 1;
        repeat (5) begin
            step();
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) quiet = 0;
        end
        late_ack = 0;
        checks++;
        if (!quiet) begin errors++; $display("FAIL late_ack_ignored: got 0 expected 1"); end
        ack_en = 1; ack_dly = 1;
        do_cmd(1'b0, 32'h1, 32'h0, 4'hF, 0, rd, er, nc, ok);
        checks++;
        if ({er, 8'(nc), rd} !== {1'b0, 8'd1, model_read(2'd1)} || !ok) begin
            errors++; $display("FAIL after_reset: got err=%b cyc=%0d dat=%h expected err=0 cyc=1 dat=%h", er, nc, rd, model_read(2'd1));
        end
    endtask

    initial begin
        cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0; rsp_ready = 0;
        ack_en = 1; ack_dly = 1; ovr_en = 0; ovr_dat = 0; late_ack = 0; wcnt = 0;
        for (int i = 0; i < 4; i++) begin regs[i] = '0; m[i] = '0; end
        test_reset();
        test_adder();
        test_wait_states();
        test_timeout();
        test_ack_last();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
